// File: rtl/ram_dp_arb_ctrl_pkg.sv
// Shared types and constants for the two-client dual-port RAM arbiter.
package ram_dp_arb_ctrl_pkg;

    localparam int NUM_CLIENTS = 2;
    localparam int RD_LATENCY  = 2;

    typedef logic client_id_t;

    typedef struct packed {
        logic       valid;
        client_id_t id;
    } issue_tag_t;

    localparam issue_tag_t TAG_IDLE = '{valid: 1'b0, id: 1'b0};

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the priority pointer only moves when both
// clients request in the same cycle.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic ptr;

    // A lone requester always wins; on contention the pointer picks the winner
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

    // Flip priority after each contended grant so neither client starves
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (req == 2'b11) begin
            ptr <= ~ptr;
        end
    end

endmodule

// File: rtl/ram_dp_arb_ctrl.sv
// Arbiter/sequencer between two request clients and a dual-port async RAM.
// Port 0 is write-only, port 1 is read-only; read data returns two cycles
// after acceptance as a one-cycle response pulse to the owning client.
module ram_dp_arb_ctrl
    import ram_dp_arb_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  c0_req_valid,
    output logic                  c0_req_ready,
    input  logic                  c0_req_we,
    input  logic [ADDR_WIDTH-1:0] c0_req_addr,
    input  logic [DATA_WIDTH-1:0] c0_req_wdata,
    output logic                  c0_rsp_valid,
    output logic [DATA_WIDTH-1:0] c0_rsp_rdata,
    input  logic                  c1_req_valid,
    output logic                  c1_req_ready,
    input  logic                  c1_req_we,
    input  logic [ADDR_WIDTH-1:0] c1_req_addr,
    input  logic [DATA_WIDTH-1:0] c1_req_wdata,
    output logic                  c1_rsp_valid,
    output logic [DATA_WIDTH-1:0] c1_rsp_rdata,
    output logic [ADDR_WIDTH-1:0] ram_address_0,
    output logic [DATA_WIDTH-1:0] ram_data_0,
    output logic                  ram_cs_0,
    output logic                  ram_we_0,
    output logic                  ram_oe_0,
    output logic [ADDR_WIDTH-1:0] ram_address_1,
    output logic                  ram_cs_1,
    output logic                  ram_we_1,
    output logic                  ram_oe_1,
    input  logic [DATA_WIDTH-1:0] ram_data_1
);

    logic [NUM_CLIENTS-1:0] wr_req;
    logic [NUM_CLIENTS-1:0] rd_req;
    logic [NUM_CLIENTS-1:0] wr_grant;
    logic [NUM_CLIENTS-1:0] rd_grant;
    logic [NUM_CLIENTS-1:0] wr_accept;
    logic [NUM_CLIENTS-1:0] rd_accept;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [DATA_WIDTH-1:0]  wr_data;
    logic [ADDR_WIDTH-1:0]  rd_addr;
    logic                   hazard;
    issue_tag_t             rd_tag;
    logic [NUM_CLIENTS-1:0] rsp_valid;

    assign wr_req = {c1_req_valid &  c1_req_we, c0_req_valid &  c0_req_we};
    assign rd_req = {c1_req_valid & ~c1_req_we, c0_req_valid & ~c0_req_we};

    rr_arb2 u_wr_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (wr_req),
        .grant (wr_grant)
    );

    rr_arb2 u_rd_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (rd_req),
        .grant (rd_grant)
    );

    assign wr_addr = wr_grant[1] ? c1_req_addr  : c0_req_addr;
    assign wr_data = wr_grant[1] ? c1_req_wdata : c0_req_wdata;
    assign rd_addr = rd_grant[1] ? c1_req_addr  : c0_req_addr;

    // A read colliding with a same-cycle write is held back so it observes the new data
    assign hazard    = (|wr_grant) && (|rd_grant) && (wr_addr == rd_addr);
    assign wr_accept = rst_n ? wr_grant : '0;
    assign rd_accept = (rst_n && !hazard) ? rd_grant : '0;

    assign c0_req_ready = wr_accept[0] | rd_accept[0];
    assign c1_req_ready = wr_accept[1] | rd_accept[1];

    assign ram_oe_0 = 1'b0;
    assign ram_we_1 = 1'b0;

    assign c0_rsp_valid = rsp_valid[0];
    assign c1_rsp_valid = rsp_valid[1];

    // Write issue stage: one-cycle cs/we strobe with registered address and data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ram_cs_0      <= 1'b0;
            ram_we_0      <= 1'b0;
            ram_address_0 <= '0;
            ram_data_0    <= '0;
        end else begin
            ram_cs_0 <= |wr_accept;
            ram_we_0 <= |wr_accept;
            if (|wr_accept) begin
                ram_address_0 <= wr_addr;
                ram_data_0    <= wr_data;
            end
        end
    end

    // Read issue stage: strobe port 1 and remember which client owns the read
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ram_cs_1      <= 1'b0;
            ram_oe_1      <= 1'b0;
            ram_address_1 <= '0;
            rd_tag        <= TAG_IDLE;
        end else begin
            ram_cs_1     <= |rd_accept;
            ram_oe_1     <= |rd_accept;
            rd_tag.valid <= |rd_accept;
            rd_tag.id    <= rd_accept[1];
            if (|rd_accept) begin
                ram_address_1 <= rd_addr;
            end
        end
    end

    // Response stage: capture async read data and pulse the owner's rsp_valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid    <= '0;
            c0_rsp_rdata <= '0;
            c1_rsp_rdata <= '0;
        end else begin
            rsp_valid <= '0;
            if (rd_tag.valid) begin
                rsp_valid[rd_tag.id] <= 1'b1;
                if (rd_tag.id) begin
                    c1_rsp_rdata <= ram_data_1;
                end else begin
                    c0_rsp_rdata <= ram_data_1;
                end
            end
        end
    end

endmodule

// File: doc/ram_dp_arb_ctrl.md
Name: ram_dp_arb_ctrl

Overview:
Two-client arbiter/sequencer in front of the dual-port asynchronous RAM. RAM port 0 is write-only and port 1 is read-only.
Each client issues read or write requests over a valid/ready handshake. The block round-robins contending clients per port and drives all RAM port controls from flops. It captures async read data and returns it as a one-cycle response pulse.
Sits between the CPU-side requesters (e.g. thread-state / register-file clients) and the RAM instance.

Parameters:
DATA_WIDTH, 8, RAM data width
ADDR_WIDTH, 8, RAM address width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active low
c0_req_valid  in  1  client 0 request valid
c0_req_ready  out  1  client 0 request accepted this cycle
c0_req_we  in  1  1 = write, 0 = read
c0_req_addr  in  ADDR_WIDTH  request address
c0_req_wdata  in  DATA_WIDTH  write data
c0_rsp_valid  out  1  read data valid pulse
c0_rsp_rdata  out  DATA_WIDTH  read data
c1_req_valid / c1_req_ready / c1_req_we / c1_req_addr / c1_req_wdata / c1_rsp_valid / c1_rsp_rdata  same as client 0
ram_address_0  out  ADDR_WIDTH  RAM port 0 address
ram_data_0  out  DATA_WIDTH  RAM port 0 write data
ram_cs_0, ram_we_0, ram_oe_0  out  1 each  RAM port 0 controls (oe_0 tied 0)
ram_address_1  out  ADDR_WIDTH  RAM port 1 address
ram_cs_1, ram_we_1, ram_oe_1  out  1 each  RAM port 1 controls (we_1 tied 0)
ram_data_1  in  DATA_WIDTH  RAM port 1 async read data

Behaviour:
- Clock and reset: single clock clk; rst_n is synchronous, active low.
- Reset values:
  - All req_ready, rsp_valid, ram_cs_*, ram_we_0, ram_oe_1 = 0.
  - Addresses, data and rsp_rdata = 0.
  - Round-robin pointers wr_rr = rd_rr = 0 (client 0 favoured first).
- Accept cycle N is the cycle where req_valid && req_ready. Ready is combinational from valid/we/addr and the pointers; a request may be withdrawn before it is accepted.
- Write port arbitration (port 0):
  - Candidates are clients with valid && we.
  - One candidate: grant it.
  - Two candidates: grant the client selected by wr_rr, then toggle wr_rr.
- Read port arbitration (port 1): same rule with rd_rr.
- One write and one read (from different clients) may both be accepted in the same cycle.
- Hazard rule: if the write and read accepted in the same cycle target the same address, only the write is accepted. The read's ready is 0 that cycle, and it is accepted no earlier than N+1, so it returns the post-write value.
- Write issue, cycle N+1 (from flops):
  - ram_cs_0 = ram_we_0 = 1 for exactly one cycle, with address and data registered.
  - Back-to-back writes give continuous cs/we with a changing address.
  - Writes have no response.
- Read issue, cycle N+1 (from flops):
  - ram_cs_1 = ram_oe_1 = 1, ram_address_1 registered.
  - ram_data_1 is sampled at the end of N+1.
- Read response, cycle N+2: the owning client's rsp_valid = 1 for one cycle, with rsp_rdata held until that client's next response. Read latency is 2 cycles, fully pipelined (one read per cycle).
- Responses have no backpressure.
- Response owner is tracked by a registered issue tag (valid + client id) per pipeline stage.
- Write issued in N+1 and read issued in N+1 to the same address cannot occur (hazard rule).
- A read issued in N+2 after a write issued in N+1 sees the new data.
- Reset mid-operation: in-flight write/read stages are flushed. No RAM strobe and no rsp_valid appear in the cycle after rst_n is sampled low.
- Pointer toggles only on contention; an uncontended grant leaves the pointer unchanged.

Decomposition:
- Shared package: client-id type (1 bit), issue-tag struct {valid, id}, constants NUM_CLIENTS=2, RD_LATENCY=2.
- One sub-module: rr_arb2 (2-way round-robin grant with contention-only pointer update). Instantiate it twice, once per port.

Test Plan:
1. Reset then idle: rst_n=0 for 3 cycles -> all ram_cs_*=0, ready=0, rsp_valid=0, pointers 0.
2. c0 write addr 0x10 data 0xA5 at N; c1 read 0x10 at N+1 -> ram_we_0=1 at N+1; c1_rsp_valid at N+3 with rdata 0xA5.
3. Both clients write continuously (c0 0x01/0x11, c1 0x02/0x22) -> grants alternate c0,c1,c0,c1; each ready high every other cycle; no write lost.
4. Same cycle: c0 write 0x20=0x3C and c1 read 0x20 -> c0 accepted, c1_req_ready=0; c1 accepted next cycle and gets 0x3C.
5. Same cycle: c0 read 0x05 and c1 write 0x06 -> both accepted N; c0_rsp_valid at N+2 with old mem[0x05].
6. Reads accepted at N and N+1, rst_n=0 at N+1 -> no ram_oe_1 at N+2, no rsp_valid at N+2/N+3.
